// File: rtl/nonce_sweep_miner_if.sv
// Bus between the nonce sweep miner and its bank of SHA-256 cores.
// The master drives nonces and the template; the cores return done pulses and hashes.
interface nonce_sweep_miner_if #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32,
    parameter int unsigned MSG_W     = 408,
    parameter int unsigned HASH_W    = 256
);
    logic [NUM_CORES-1:0]         core_start;
    logic [NUM_CORES*NONCE_W-1:0] core_nonce;
    logic [MSG_W-1:0]             core_msg;
    logic [NUM_CORES-1:0]         core_done;
    logic [NUM_CORES*HASH_W-1:0]  core_hash;

    modport master (
        output core_start,
        output core_nonce,
        output core_msg,
        input  core_done,
        input  core_hash
    );

    modport slave (
        input  core_start,
        input  core_nonce,
        input  core_msg,
        output core_done,
        output core_hash
    );
endinterface

// File: rtl/nonce_sweep_miner.sv
// Sweeps an inclusive nonce range over NUM_CORES external SHA-256 cores and
// reports the first hash strictly below the loaded target.
module nonce_sweep_miner #(
    parameter int unsigned NUM_CORES = 4,
    parameter int unsigned NONCE_W   = 32,
    parameter int unsigned MSG_W     = 408,
    parameter int unsigned HASH_W    = 256
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                new_target,
    input  logic [HASH_W-1:0]   input_target,
    input  logic                new_msg,
    input  logic [MSG_W-1:0]    input_msg,
    input  logic [NONCE_W-1:0]  nonce_base,
    input  logic [NONCE_W-1:0]  nonce_limit,
    input  logic                abort,
    nonce_sweep_miner_if.master cores,
    output logic [HASH_W-1:0]   target_output,
    output logic                busy,
    output logic                valid_btc,
    output logic                exhausted,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic [HASH_W-1:0]   found_hash
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state, state_n;
    logic [HASH_W-1:0]    target_n, found_hash_n;
    logic [MSG_W-1:0]     msg_q, msg_n;
    logic [NONCE_W-1:0]   next_nonce, next_nonce_n, limit_q, limit_n, found_nonce_n;
    logic [NONCE_W-1:0]   nonce_q [NUM_CORES];
    logic [NONCE_W-1:0]   nonce_n [NUM_CORES];
    logic [NUM_CORES-1:0] core_busy, core_busy_n, start_q, start_n;
    logic                 issued_all, issued_all_n, suppress, suppress_n;
    logic                 busy_n, valid_n, exh_n;

    logic [NUM_CORES-1:0] done_v, busy_after;
    logic                 hit, issue, picked;
    logic [NONCE_W-1:0]   hit_nonce, issue_nonce;
    logic [HASH_W-1:0]    hit_hash;

    // A done only counts for a core we actually started; it frees the core this cycle.
    assign done_v     = core_busy & cores.core_done;
    assign busy_after = core_busy & ~cores.core_done;

    // Lowest-index completing core with a hash strictly below the target.
    always_comb begin
        hit       = 1'b0;
        hit_nonce = '0;
        hit_hash  = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            if (!hit && done_v[i] && (cores.core_hash[i*HASH_W +: HASH_W] < target_output)) begin
                hit       = 1'b1;
                hit_nonce = nonce_q[i];
                hit_hash  = cores.core_hash[i*HASH_W +: HASH_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        target_n      = target_output;
        msg_n         = msg_q;
        next_nonce_n  = next_nonce;
        limit_n       = limit_q;
        nonce_n       = nonce_q;
        core_busy_n   = busy_after;
        start_n       = '0;
        issued_all_n  = issued_all;
        suppress_n    = suppress;
        found_nonce_n = found_nonce;
        found_hash_n  = found_hash;
        valid_n       = 1'b0;
        exh_n         = 1'b0;
        issue         = 1'b0;
        picked        = 1'b0;
        issue_nonce   = next_nonce;

        if (new_target && !busy) begin
            target_n = input_target;
        end

        unique case (state)
            IDLE: begin
                if (new_msg) begin
                    msg_n         = input_msg;
                    limit_n       = nonce_limit;
                    found_nonce_n = '0;
                    found_hash_n  = '0;
                    suppress_n    = 1'b0;
                    issued_all_n  = 1'b0;
                    // First nonce goes out straight from the accept edge.
                    if (nonce_limit >= nonce_base) begin
                        state_n     = RUN;
                        issue       = 1'b1;
                        issue_nonce = nonce_base;
                    end else begin
                        exh_n = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_n    = DRAIN;
                    suppress_n = 1'b1;
                end else if (hit) begin
                    found_nonce_n = hit_nonce;
                    found_hash_n  = hit_hash;
                    state_n       = DRAIN;
                end else if (issued_all && (busy_after == '0)) begin
                    exh_n   = 1'b1;
                    state_n = IDLE;
                end else if (!issued_all) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                if (abort) begin
                    suppress_n = 1'b1;
                end
                if (busy_after == '0) begin
                    state_n = IDLE;
                    valid_n = !suppress && !abort;
                end
            end
            default: state_n = IDLE;
        endcase

        // Hand the nonce to the lowest-index free core; no wrap past the limit.
        if (issue) begin
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                if (!picked && !busy_after[i]) begin
                    picked         = 1'b1;
                    start_n[i]     = 1'b1;
                    core_busy_n[i] = 1'b1;
                    nonce_n[i]     = issue_nonce;
                end
            end
            if (picked) begin
                next_nonce_n = issue_nonce + NONCE_W'(1);
                issued_all_n = (issue_nonce == limit_n);
            end
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            target_output <= '0;
            msg_q         <= '0;
            next_nonce    <= '0;
            limit_q       <= '0;
            core_busy     <= '0;
            start_q       <= '0;
            issued_all    <= 1'b0;
            suppress      <= 1'b0;
            busy          <= 1'b0;
            valid_btc     <= 1'b0;
            exhausted     <= 1'b0;
            found_nonce   <= '0;
            found_hash    <= '0;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                nonce_q[i] <= '0;
            end
        end else begin
            state         <= state_n;
            target_output <= target_n;
            msg_q         <= msg_n;
            next_nonce    <= next_nonce_n;
            limit_q       <= limit_n;
            core_busy     <= core_busy_n;
            start_q       <= start_n;
            issued_all    <= issued_all_n;
            suppress      <= suppress_n;
            busy          <= busy_n;
            valid_btc     <= valid_n;
            exhausted     <= exh_n;
            found_nonce   <= found_nonce_n;
            found_hash    <= found_hash_n;
            nonce_q       <= nonce_n;
        end
    end

    assign cores.core_start = start_q;
    assign cores.core_msg   = msg_q;

    for (genvar g = 0; g < int'(NUM_CORES); g++) begin : g_nonce
        assign cores.core_nonce[g*NONCE_W +: NONCE_W] = nonce_q[g];
    end

endmodule

// File: tb/tb_nonce_sweep_miner.sv
// Scoreboard bench for nonce_sweep_miner: directed sweeps push expected core
// starts and result pulses; a negedge monitor pops and compares them.
module tb_nonce_sweep_miner;

    localparam int unsigned NC = 4;
    localparam int unsigned NW = 32;
    localparam int unsigned MW = 408;
    localparam int unsigned HW = 256;

    localparam logic [HW-1:0] TGT   = {4'h1, 252'h0};
    localparam logic [HW-1:0] ONES  = '1;
    localparam logic [HW-1:0] H3    = {32'h0000_0001, 224'h0};
    localparam logic [HW-1:0] H1    = {32'h0000_0100, 224'h0};
    localparam logic [HW-1:0] H2    = {32'h0000_0002, 224'h0};
    localparam logic [MW-1:0] MSG_A = {51{8'hA5}};
    localparam logic [MW-1:0] MSG_B = {51{8'h3C}};

    logic          clk, n_rst, new_target, new_msg, abort;
    logic [HW-1:0] input_target, target_output, found_hash;
    logic [MW-1:0] input_msg;
    logic [NW-1:0] nonce_base, nonce_limit, found_nonce;
    logic          busy, valid_btc, exhausted;

    nonce_sweep_miner_if #(.NUM_CORES(NC), .NONCE_W(NW), .MSG_W(MW), .HASH_W(HW)) bus();

    nonce_sweep_miner #(.NUM_CORES(NC), .NONCE_W(NW), .MSG_W(MW), .HASH_W(HW)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .new_target    (new_target),
        .input_target  (input_target),
        .new_msg       (new_msg),
        .input_msg     (input_msg),
        .nonce_base    (nonce_base),
        .nonce_limit   (nonce_limit),
        .abort         (abort),
        .cores         (bus),
        .target_output (target_output),
        .busy          (busy),
        .valid_btc     (valid_btc),
        .exhausted     (exhausted),
        .found_nonce   (found_nonce),
        .found_hash    (found_hash)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 = core start, 1 = valid_btc, 2 = exhausted
    typedef struct {
        int            kind;
        int            core;
        logic [NW-1:0] nonce;
        logic [HW-1:0] hash;
    } ev_t;

    ev_t exp_q[$];
    int  passed = 0;
    int  total  = 0;

    // Core model configuration: up to two winning nonces, one slow nonce.
    logic          hit_en [2];
    logic [NW-1:0] hit_n  [2];
    logic [HW-1:0] hit_h  [2];
    logic          slow_en;
    logic [NW-1:0] slow_n;
    int            lat_cnt [NC] = '{default: 0};
    logic [NW-1:0] mnonce  [NC] = '{default: '0};

    task automatic check(input string name, input logic ok, input logic [HW-1:0] act,
                         input logic [HW-1:0] req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic compare_ev(input ev_t ob);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got kind %0d core %0d nonce %h, required none",
                     ob.kind, ob.core, ob.nonce);
            return;
        end
        e = exp_q.pop_front();
        if (ob.kind == e.kind && ob.core == e.core && ob.nonce == e.nonce && ob.hash == e.hash)
            passed++;
        else
            $display("FAIL event: got kind %0d core %0d nonce %h hash %h, required kind %0d core %0d nonce %h hash %h",
                     ob.kind, ob.core, ob.nonce, ob.hash, e.kind, e.core, e.nonce, e.hash);
    endtask

    task automatic exp_start(input int c, input logic [NW-1:0] n);
        ev_t e;
        e.kind = 0; e.core = c; e.nonce = n; e.hash = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_valid(input logic [NW-1:0] n, input logic [HW-1:0] h);
        ev_t e;
        e.kind = 1; e.core = 0; e.nonce = n; e.hash = h;
        exp_q.push_back(e);
    endtask

    task automatic exp_exh();
        ev_t e;
        e.kind = 2; e.core = 0; e.nonce = '0; e.hash = '0;
        exp_q.push_back(e);
    endtask

    function automatic logic [HW-1:0] model_hash(input logic [NW-1:0] n);
        for (int k = 0; k < 2; k++) begin
            if (hit_en[k] && hit_n[k] == n) return hit_h[k];
        end
        return ONES;
    endfunction

    // SHA core model: done 3 cycles after the start is seen (4 for the slow nonce).
    always @(negedge clk) begin : core_model
        logic [NC-1:0]    d;
        logic [NC*HW-1:0] h;
        d = '0;
        h = '0;
        for (int i = 0; i < int'(NC); i++) begin
            if (lat_cnt[i] > 0) begin
                lat_cnt[i]--;
                if (lat_cnt[i] == 0) begin
                    d[i] = 1'b1;
                    h[i*HW +: HW] = model_hash(mnonce[i]);
                end
            end
            if (bus.core_start[i]) begin
                mnonce[i]  = bus.core_nonce[i*NW +: NW];
                lat_cnt[i] = (slow_en && mnonce[i] == slow_n) ? 4 : 3;
            end
        end
        bus.core_done = d;
        bus.core_hash = h;
    end

    // Monitor: every start pulse and result pulse is matched against the queue.
    always @(negedge clk) begin : monitor
        ev_t ob;
        if (n_rst) begin
            for (int i = 0; i < int'(NC); i++) begin
                if (bus.core_start[i]) begin
                    ob.kind = 0; ob.core = i; ob.nonce = bus.core_nonce[i*NW +: NW]; ob.hash = '0;
                    compare_ev(ob);
                end
            end
            if (valid_btc || exhausted)
                check("pulse_exclusive", !(valid_btc && exhausted),
                      HW'({valid_btc, exhausted}), HW'(2'b00));
            if (valid_btc) begin
                ob.kind = 1; ob.core = 0; ob.nonce = found_nonce; ob.hash = found_hash;
                compare_ev(ob);
            end
            if (exhausted) begin
                ob.kind = 2; ob.core = 0; ob.nonce = '0; ob.hash = '0;
                compare_ev(ob);
            end
        end
    end

    task automatic start_sweep(input logic [NW-1:0] b, input logic [NW-1:0] l,
                               input logic [MW-1:0] m);
        @(negedge clk);
        new_msg = 1'b1; nonce_base = b; nonce_limit = l; input_msg = m;
        @(negedge clk);
        new_msg = 1'b0;
    endtask

    task automatic finish_sweep(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size() == 0 && !busy, HW'(exp_q.size()), '0);
        exp_q.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic set_hits(input logic e0, input logic [NW-1:0] n0, input logic [HW-1:0] h0,
                            input logic e1, input logic [NW-1:0] n1, input logic [HW-1:0] h1);
        hit_en[0] = e0; hit_n[0] = n0; hit_h[0] = h0;
        hit_en[1] = e1; hit_n[1] = n1; hit_h[1] = h1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; new_target = 1'b0; new_msg = 1'b0; abort = 1'b0;
        input_target = '0; input_msg = '0; nonce_base = '0; nonce_limit = '0;
        bus.core_done = '0; bus.core_hash = '0;
        slow_en = 1'b0; slow_n = '0;
        set_hits(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_target", target_output == '0, target_output, '0);
        check("rst_flags", {busy, valid_btc, exhausted} == 3'b000, HW'({busy, valid_btc, exhausted}), '0);
        check("rst_found", found_nonce == '0 && found_hash == '0, found_hash, '0);
        check("rst_start", bus.core_start == '0, HW'(bus.core_start), '0);
        n_rst = 1'b1;

        // Target load
        @(negedge clk); new_target = 1'b1; input_target = TGT;
        @(negedge clk); new_target = 1'b0;
        @(negedge clk);
        check("target_load", target_output == TGT, target_output, TGT);
        check("idle_busy", busy == 1'b0, HW'(busy), '0);

        // Full range, no hit; new_msg and new_target ignored while busy
        for (int n = 0; n < 4; n++) exp_start(n, NW'(n));
        exp_start(0, 32'd4); exp_start(1, 32'd5); exp_exh();
        start_sweep(32'd0, 32'd5, MSG_A);
        check("busy_run", busy == 1'b1, HW'(busy), HW'(1));
        check("core_msg", bus.core_msg == MSG_A, HW'(bus.core_msg), HW'(MSG_A));
        new_msg = 1'b1; nonce_base = 32'd100; nonce_limit = 32'd200; input_msg = MSG_B;
        new_target = 1'b1; input_target = ONES;
        @(negedge clk);
        new_msg = 1'b0; new_target = 1'b0;
        finish_sweep("sweep_nohit", 60);
        check("target_kept", target_output == TGT, target_output, TGT);
        check("core_msg_kept", bus.core_msg == MSG_A, HW'(bus.core_msg), HW'(MSG_A));

        // Nonce 3 wins; later nonces are not issued after its done cycle
        set_hits(1'b1, 32'd3, H3, 1'b0, '0, '0);
        for (int n = 0; n < 4; n++) exp_start(n, NW'(n));
        exp_start(0, 32'd4); exp_start(1, 32'd5); exp_start(2, 32'd6);
        exp_valid(32'd3, H3);
        start_sweep(32'd0, 32'd9, MSG_B);
        finish_sweep("sweep_hit3", 60);
        check("found_nonce_hold", found_nonce == 32'd3, HW'(found_nonce), HW'(32'd3));
        check("found_hash_hold", found_hash == H3, found_hash, H3);

        // Nonces 1 and 2 hit in the same cycle: lower core index wins
        set_hits(1'b1, 32'd1, H1, 1'b1, 32'd2, H2);
        slow_en = 1'b1; slow_n = 32'd1;
        for (int n = 0; n < 4; n++) exp_start(n, NW'(n));
        exp_start(0, 32'd4);
        exp_valid(32'd1, H1);
        start_sweep(32'd0, 32'd9, MSG_A);
        finish_sweep("sweep_tie", 60);
        check("tie_nonce", found_nonce == 32'd1, HW'(found_nonce), HW'(32'd1));
        slow_en = 1'b0;
        set_hits(1'b0, '0, '0, 1'b0, '0, '0);

        // Top of range: no wrap to 0; new_msg clears found_*
        exp_start(0, 32'hFFFF_FFFE); exp_start(1, 32'hFFFF_FFFF); exp_exh();
        start_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, MSG_B);
        check("found_cleared", found_nonce == '0 && found_hash == '0, found_hash, '0);
        finish_sweep("sweep_top", 40);

        exp_start(0, 32'hFFFF_FFFF); exp_exh();
        start_sweep(32'hFFFF_FFFF, 32'hFFFF_FFFF, MSG_B);
        finish_sweep("sweep_single", 40);

        // Empty range: exhausted right after new_msg, no starts
        exp_exh();
        start_sweep(32'd5, 32'd4, MSG_A);
        check("empty_exh_timing", exhausted == 1'b1, HW'(exhausted), HW'(1));
        check("empty_busy", busy == 1'b0, HW'(busy), '0);
        finish_sweep("sweep_empty", 20);

        // Abort with two cores busy: no more starts, no result pulse
        exp_start(0, 32'd0); exp_start(1, 32'd1);
        start_sweep(32'd0, 32'd9, MSG_A);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy == 1'b1, HW'(busy), HW'(1));
        finish_sweep("sweep_abort", 40);

        // Asynchronous reset mid-run
        exp_start(0, 32'd0); exp_start(1, 32'd1); exp_start(2, 32'd2);
        start_sweep(32'd0, 32'd9, MSG_B);
        repeat (2) @(negedge clk);
        #2;
        check("pre_reset_starts", exp_q.size() == 0, HW'(exp_q.size()), '0);
        n_rst = 1'b0;
        #1;
        check("arst_target", target_output == '0, target_output, '0);
        check("arst_flags", {busy, valid_btc, exhausted} == 3'b000, HW'({busy, valid_btc, exhausted}), '0);
        check("arst_core", bus.core_start == '0 && bus.core_nonce == '0 && bus.core_msg == '0,
              HW'(bus.core_nonce), '0);
        check("arst_found", found_nonce == '0 && found_hash == '0, found_hash, '0);
        @(negedge clk);
        n_rst = 1'b1;

        // Stale dones from before reset must not disturb a fresh sweep
        exp_start(0, 32'd10); exp_start(1, 32'd11); exp_exh();
        start_sweep(32'd10, 32'd11, MSG_A);
        finish_sweep("sweep_after_reset", 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/nonce_sweep_miner.md
Name: nonce_sweep_miner

Overview:
- Parametrised successor to the single-message miner top level.
- Loads a 256-bit target and a header template, then sweeps a nonce range across NUM_CORES external SHA-256 cores using a start/done handshake.
- Compares each returned hash against the target and reports the first winning nonce and its hash.
- Sits between the host-facing load logic and the bank of SHA cores.

Parameters:
- NUM_CORES, 4, number of attached SHA-256 cores (1..16).
- NONCE_W, 32, nonce width in bits.
- MSG_W, 408, header template width (nonce excluded).
- HASH_W, 256, hash and target width.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low.
- new_target  in  1  load input_target (1-cycle strobe).
- input_target  in  HASH_W  difficulty target.
- new_msg  in  1  start sweep (1-cycle strobe).
- input_msg  in  MSG_W  header template.
- nonce_base  in  NONCE_W  first nonce, inclusive.
- nonce_limit  in  NONCE_W  last nonce, inclusive.
- abort  in  1  stop sweep, no report.
- core_start  out  NUM_CORES  per-core 1-cycle start pulse.
- core_nonce  out  NUM_CORES*NONCE_W  per-core nonce; slice i is core i; held while core busy.
- core_msg  out  MSG_W  latched template, shared by all cores.
- core_done  in  NUM_CORES  per-core 1-cycle done pulse.
- core_hash  in  NUM_CORES*HASH_W  per-core hash; valid with core_done.
- target_output  out  HASH_W  current target register.
- busy  out  1  sweep in progress.
- valid_btc  out  1  1-cycle pulse: winning nonce found.
- exhausted  out  1  1-cycle pulse: range finished, no hit.
- found_nonce  out  NONCE_W  winning nonce.
- found_hash  out  HASH_W  winning hash.

Behaviour:
- Reset: all outputs 0, target 0, all core_busy flags 0, state IDLE.
- Target load:
  - new_target is accepted only while busy=0; ignored otherwise.
  - target_output updates on the edge after the strobe.
- States and transitions:
  - IDLE:
    - On new_msg, latch input_msg, nonce_base and nonce_limit; clear found_nonce and found_hash.
    - If limit >= base, go to RUN. Otherwise pulse exhausted on the next cycle and stay in IDLE.
    - new_msg while busy=1 is ignored.
  - RUN:
    - Issue at most one nonce per cycle, to the lowest-index core with core_busy=0.
    - Issue means: core_start[i]=1 for one cycle, core_nonce slice i = next_nonce, core_busy[i] set.
    - The first issue is the cycle after new_msg is accepted.
    - next_nonce increments after each issue. When the issued nonce equals limit, set issued_all; no further issues.
    - next_nonce never wraps. Base=all-ones with limit=all-ones issues exactly one nonce.
  - Completion:
    - core_done[i] with core_busy[i]=1 clears core_busy[i]. core_done on an idle core is ignored.
    - Hit test: hash < target_output, unsigned, strict.
    - On the first hit, latch found_nonce and found_hash, then go to DRAIN.
    - If several hits complete in the same cycle, the lowest core index wins.
    - A core may be re-issued in the same cycle its done is seen.
    - If issued_all is set and no core is busy with no hit: pulse exhausted, go to IDLE.
  - DRAIN:
    - No issues. Later hits are ignored.
    - Once all core_busy=0, pulse valid_btc for one cycle and go to IDLE.
    - found_nonce and found_hash hold until the next accepted new_msg.
  - abort:
    - In RUN, go to DRAIN with the report suppressed.
    - After drain, return to IDLE with no valid_btc or exhausted pulse.
    - In DRAIN, abort suppresses a pending valid_btc.
- busy=1 in RUN and DRAIN only.
- valid_btc and exhausted are never asserted together.
- Asynchronous reset mid-sweep returns everything to reset values immediately. Outstanding core_done pulses after reset are ignored.

Test Plan:
- Reset, then new_target with 0x1000...0 -> target_output = 0x1000...0 two cycles later; busy=0; all other outputs 0.
- NUM_CORES=4, base=0, limit=5; model cores return 0xFF..FF after 3 cycles -> starts to cores 0,1,2,3 with nonces 0..3, then 4 and 5 as cores free; exactly 6 core_start pulses; one exhausted pulse; valid_btc never asserted.
- Same range; core holding nonce 3 returns 0x0000_0001_00...0 -> no core_start after that done cycle; one valid_btc pulse after the drain; found_nonce=3; found_hash = returned value.
- Cores 1 and 2 (nonces 1 and 2) both return hits in the same cycle -> found_nonce=1.
- base=0xFFFF_FFFE, limit=0xFFFF_FFFF -> exactly 2 starts, no nonce 0 issued, exhausted pulse. base=5, limit=4 -> zero starts, exhausted one cycle after new_msg.
- abort asserted mid-RUN with 2 cores busy -> no new starts; busy drops after both done; no valid_btc or exhausted pulse. n_rst asserted mid-RUN -> all outputs 0 in the same cycle.
